butterfly_trace_probe: RTL

// Synthesizable capture probe for the radix-2 FFT butterfly core.
// - Taps the iact/oact strobes and operand/result buses of all NUM_STAGES butterflies; one stage, selected at run time, is traced.
// - Aligns each input tuple (A, B, twiddle) with its result across the fixed butterfly latency.
// - Packs the aligned tuple into a record and queues it in a FIFO, read out via a valid/ready handshake (e.g. by the SPI dumper).

---
 rtl/butterfly_trace_probe.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/butterfly_trace_probe.sv
// butterfly_trace_probe: traces one run-time selected FFT butterfly stage into a record FIFO.
// Optional arithmetic checker enabled by defining BFLY_PROBE_CHECK_EN.
`default_nettype none

module butterfly_trace_probe #(
    parameter int DATA_W     = 16,
    parameter int LATENCY    = 6,
    parameter int NUM_STAGES = 10,
    parameter int FIFO_DEPTH = 64,
    parameter int IDX_W      = 11,
    localparam int STAGE_W   = $clog2(NUM_STAGES),
    localparam int REC_W     = 10*DATA_W + IDX_W + STAGE_W + 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [STAGE_W-1:0]           stage_sel,
    input  logic [NUM_STAGES-1:0]        iact,
    input  logic [NUM_STAGES-1:0]        oact,
    input  logic [NUM_STAGES*6*DATA_W-1:0] in_bus,
    input  logic [NUM_STAGES*4*DATA_W-1:0] out_bus,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [REC_W-1:0]             rec_data,
    output logic [15:0]                  drop_cnt,
    output logic                         misalign,
    output logic                         check_err
);

    localparam int IN_W  = 6*DATA_W;
    localparam int OUT_W = 4*DATA_W;
    localparam int AW    = $clog2(FIFO_DEPTH);

    logic [STAGE_W-1:0] sel_q;
    logic               sel_iact;
    logic               sel_oact;
    logic [IN_W-1:0]    sel_in;
    logic [OUT_W-1:0]   sel_out;

    // Out-of-range selections simply see an idle stage.
    always_comb begin
        sel_iact = 1'b0;
        sel_oact = 1'b0;
        sel_in   = '0;
        sel_out  = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (sel_q == STAGE_W'(s)) begin
                sel_iact = iact[s];
                sel_oact = oact[s];
                sel_in   = in_bus[s*IN_W +: IN_W];
                sel_out  = out_bus[s*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q <= '0;
        end else if (!enable) begin
            sel_q <= stage_sel;
        end
    end

    logic [LATENCY-1:0] dl_v;
    logic [IN_W-1:0]    dl_d [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_d[i] <= '0;
            end
        end else begin
            dl_v[0] <= sel_iact & enable;
            dl_d[0] <= sel_in;
            for (int i = 1; i < LATENCY; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_d[i] <= dl_d[i-1];
            end
        end
    end

    logic            head_v;
    logic [IN_W-1:0] head_d;
    logic            wr;
    logic            mis;
    logic            chk;
    logic [IDX_W-1:0] index;
    logic [REC_W-1:0] rec;

    assign head_v = dl_v[LATENCY-1];
    assign head_d = dl_d[LATENCY-1];
    assign wr     = sel_oact;
    assign mis    = ~head_v;
    assign rec    = {chk, mis, sel_q, index, sel_out, head_d};

`ifdef BFLY_PROBE_CHECK_EN
    logic signed [DATA_W:0] sum_re;
    logic signed [DATA_W:0] sum_im;
    logic [DATA_W-1:0]      exp_re;
    logic [DATA_W-1:0]      exp_im;

    // Expected oA is the halved sum, formed one bit wider to keep the carry.
    always_comb begin
        sum_re = {head_d[DATA_W-1], head_d[DATA_W-1:0]}
               + {head_d[3*DATA_W-1], head_d[3*DATA_W-1:2*DATA_W]};
        sum_im = {head_d[2*DATA_W-1], head_d[2*DATA_W-1:DATA_W]}
               + {head_d[4*DATA_W-1], head_d[4*DATA_W-1:3*DATA_W]};
        exp_re = DATA_W'(sum_re >>> 1);
        exp_im = DATA_W'(sum_im >>> 1);
        chk    = head_v && ((sel_out[DATA_W-1:0] != exp_re) ||
                            (sel_out[2*DATA_W-1:DATA_W] != exp_im));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            check_err <= 1'b0;
        end else if (wr && chk) begin
            check_err <= 1'b1;
        end
    end
`else
    assign chk       = 1'b0;
    assign check_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index    <= '0;
            misalign <= 1'b0;
        end else begin
            if (!enable && (stage_sel != sel_q)) begin
                index <= '0;
            end else if (wr) begin
                index <= index + IDX_W'(2);
            end
            if (wr && mis) begin
                misalign <= 1'b1;
            end
        end
    end

    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             full;
    logic             pop;
    logic             push;

    assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
    assign rec_valid = (cnt != '0);
    assign pop       = rec_valid & rec_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = wr & (~full | pop);
    assign rec_data  = rec_valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= rec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (wr && !push && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire
